// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Time-multiplexes a NUM_DIGITS-nibble hex value onto one shared one-hot
//   7-segment decoder. A one-entry pending buffer accepts new values through
//   a valid/ready handshake. The buffered value is promoted to the displayed
//   value only at a frame boundary, so a single frame never mixes two values.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load_valid  load_value is valid
//   load_ready  pending buffer empty, a load is accepted this cycle
//   load_value  hex value, digit 0 in bits [3:0]
//   blank_lz    1 = blank leading zero digits (digit 0 is never blanked)
//   dec_onehot  one-hot digit code to the decoder (bit n = value n), 0 = blank
//   digit_sel   active-high one-hot digit enable
//   frame_done  one-cycle pulse after the last digit step of a frame
module hex_display_scanner #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [4*NUM_DIGITS-1:0]   load_value,
   input  logic                      blank_lz,
   output logic [15:0]               dec_onehot,
   output logic [NUM_DIGITS-1:0]     digit_sel,
   output logic                      frame_done
);

   localparam int unsigned VAL_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);

   typedef enum logic {
      BLANK = 1'b0,
      SCAN  = 1'b1
   } state_t;

   state_t               state, state_d;
   logic [VAL_W-1:0]     pend, pend_d;
   logic                 pend_valid, pend_valid_d;
   logic [VAL_W-1:0]     active, active_d;
   logic [IDX_W-1:0]     idx, idx_d;
   logic [PRE_W-1:0]     prescaler, prescaler_d;
   logic [15:0]          dec_d;
   logic [NUM_DIGITS-1:0] sel_d;
   logic                 frame_done_d;
   logic                 load_ready_d;

   logic [3:0]           cur_nib;
   logic                 upper_zero;

   // Current digit nibble and "this and all higher digits are zero" flag
   always_comb begin
      cur_nib    = 4'h0;
      upper_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) cur_nib = active[4*i +: 4];
         if ((IDX_W'(i) >= idx) && (active[4*i +: 4] != 4'h0)) upper_zero = 1'b0;
      end
   end

   // Next-state, buffer and output logic
   always_comb begin
      state_d      = state;
      pend_d       = pend;
      pend_valid_d = pend_valid;
      active_d     = active;
      idx_d        = idx;
      prescaler_d  = prescaler;
      dec_d        = 16'h0000;
      sel_d        = '0;
      frame_done_d = 1'b0;

      // Accept only into an empty buffer; an apply can never collide with
      // this because apply requires the buffer to be full.
      if (load_valid && !pend_valid) begin
         pend_d       = load_value;
         pend_valid_d = 1'b1;
      end

      case (state)
         BLANK: begin
            if (pend_valid) begin
               active_d     = pend;
               pend_valid_d = 1'b0;
               idx_d        = '0;
               prescaler_d  = '0;
               state_d      = SCAN;
            end
         end
         SCAN: begin
            sel_d = NUM_DIGITS'(1) << idx;
            if (blank_lz && (idx != '0) && upper_zero) dec_d = 16'h0000;
            else                                       dec_d = 16'(1) << cur_nib;

            if (prescaler == LAST_PRE) begin
               prescaler_d = '0;
               if (idx == LAST_IDX) begin
                  idx_d        = '0;
                  frame_done_d = 1'b1;
                  // Frame boundary: the only point a new value may take over
                  if (pend_valid) begin
                     active_d     = pend;
                     pend_valid_d = 1'b0;
                  end
               end else begin
                  idx_d = idx + IDX_W'(1);
               end
            end else begin
               prescaler_d = prescaler + PRE_W'(1);
            end
         end
         default: state_d = BLANK;
      endcase

      load_ready_d = !pend_valid_d;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BLANK;
         pend       <= '0;
         pend_valid <= 1'b0;
         active     <= '0;
         idx        <= '0;
         prescaler  <= '0;
         dec_onehot <= 16'h0000;
         digit_sel  <= '0;
         frame_done <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         state      <= state_d;
         pend       <= pend_d;
         pend_valid <= pend_valid_d;
         active     <= active_d;
         idx        <= idx_d;
         prescaler  <= prescaler_d;
         dec_onehot <= dec_d;
         digit_sel  <= sel_d;
         frame_done <= frame_done_d;
         load_ready <= load_ready_d;
      end
   end

endmodule
